instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 23 ++
 rtl/instr_encoder_pack.sv | 41 ++++
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RISC-V opcode constants, halt word and loader state type.
// The processor's control decoder imports the same opcode constants.
package instr_encoder_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_U    = 7'b0110111;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACCEPT,
        WRITE,
        HALTW,
        DONE
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packing of instruction fields into a 32-bit RISC-V word.
// known is low for unsupported opcodes, which pack to all zeros.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        known
);

    always_comb begin
        word  = 32'h0;
        known = 1'b1;
        case (opcode)
            OP_R:
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_I, OP_LOAD, OP_JALR:
                word = {imm[11:0], rs1, funct3, rd, opcode};
            OP_S:
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            // imm[0] is implicit zero for branch targets and is dropped
            OP_B:
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            OP_U:
                word = {imm[31:12], rd, opcode};
            OP_J:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                word  = 32'h0;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs instruction bundles, writes them to instruction memory
// in order, and terminates the image with a halt word.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [6:0]        inOpcode,
    input  logic [4:0]        inRd,
    input  logic [4:0]        inRs1,
    input  logic [4:0]        inRs2,
    input  logic [2:0]        inFunct3,
    input  logic [6:0]        inFunct7,
    input  logic [31:0]       inImm,
    input  logic              inLast,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    input  logic              memAck,
    input  logic              restart,
    output logic              done,
    output logic              error,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              skip_halt_q, skip_halt_d;
    logic              error_q, error_d;
    logic              full_q, full_d;

    logic [31:0]       packed_word;
    logic              packed_known;

    instr_pack u_pack (
        .opcode (inOpcode),
        .rd     (inRd),
        .rs1    (inRs1),
        .rs2    (inRs2),
        .funct3 (inFunct3),
        .funct7 (inFunct7),
        .imm    (inImm),
        .word   (packed_word),
        .known  (packed_known)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ACCEPT;
            ptr_q       <= '0;
            count_q     <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            skip_halt_q <= 1'b0;
            error_q     <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            last_q      <= last_d;
            skip_halt_q <= skip_halt_d;
            error_q     <= error_d;
            full_q      <= full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        word_d      = word_q;
        last_d      = last_q;
        skip_halt_d = skip_halt_q;
        error_d     = error_q;
        full_d      = full_q;
        inReady     = 1'b0;
        memWe       = 1'b0;
        memAddr     = ptr_q;
        memWdata    = word_q;
        done        = 1'b0;

        case (state_q)
            ACCEPT: begin
                inReady = 1'b1;
                if (inValid) begin
                    word_d      = packed_word;
                    last_d      = inLast | ~packed_known;
                    skip_halt_d = ~packed_known;
                    if (!packed_known) begin
                        error_d = 1'b1;
                    end
                    state_d = WRITE;
                end
            end
            WRITE: begin
                memWe = 1'b1;
                if (memAck) begin
                    ptr_d   = ptr_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                    // an unknown opcode's zero word already acts as the halt
                    if (skip_halt_q) begin
                        state_d = DONE;
                    end else if (last_q) begin
                        state_d = HALTW;
                    end else if (ptr_d == LAST_ADDR) begin
                        state_d = HALTW;
                        full_d  = 1'b1;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            HALTW: begin
                memWe    = 1'b1;
                memWdata = HALT_WORD;
                if (memAck) begin
                    count_d = count_q + CNT_ONE;
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (restart) begin
                    ptr_d   = '0;
                    count_d = '0;
                    error_d = 1'b0;
                    full_d  = 1'b0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    assign error = error_q;
    assign full  = full_q;
    assign count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 256-word and a 4-word loader share
// stimulus, selected by sel; a monitor checks every acknowledged write.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, sel, in_valid, in_last, restart, mem_ack;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;

    logic        a_ready, a_we, a_done, a_error, a_full;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    logic        b_ready, b_we, b_done, b_error, b_full;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    logic        m_ready, m_we, m_done, m_error, m_full;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_count;

    assign m_ready = sel ? b_ready : a_ready;
    assign m_we    = sel ? b_we    : a_we;
    assign m_done  = sel ? b_done  : a_done;
    assign m_error = sel ? b_error : a_error;
    assign m_full  = sel ? b_full  : a_full;
    assign m_addr  = sel ? {6'b0, b_addr} : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_count = sel ? {6'b0, b_count} : a_count;

    instr_encoder #(.DEPTH(256)) dut_a (
        .clk(clk), .rstN(rstN), .inValid(in_valid && !sel), .inReady(a_ready),
        .inOpcode(in_opcode), .inRd(in_rd), .inRs1(in_rs1), .inRs2(in_rs2),
        .inFunct3(in_funct3), .inFunct7(in_funct7), .inImm(in_imm), .inLast(in_last),
        .memWe(a_we), .memAddr(a_addr), .memWdata(a_wdata), .memAck(mem_ack && !sel),
        .restart(restart && !sel), .done(a_done), .error(a_error), .full(a_full),
        .count(a_count)
    );

    instr_encoder #(.DEPTH(4)) dut_b (
        .clk(clk), .rstN(rstN), .inValid(in_valid && sel), .inReady(b_ready),
        .inOpcode(in_opcode), .inRd(in_rd), .inRs1(in_rs1), .inRs2(in_rs2),
        .inFunct3(in_funct3), .inFunct7(in_funct7), .inImm(in_imm), .inLast(in_last),
        .memWe(b_we), .memAddr(b_addr), .memWdata(b_wdata), .memAck(mem_ack && sel),
        .restart(restart && sel), .done(b_done), .error(b_error), .full(b_full),
        .count(b_count)
    );

    exp_t exp_q[$];
    int   vec_cnt   = 0;
    int   err_cnt   = 0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        vec_cnt++;
        err_cnt++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", name);
    endtask

    // Memory model: acknowledges each write request after ack_delay stall cycles
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) wait_cnt = 0;
            mem_ack = 1'b0;
            if (!rstN) begin
                wait_cnt = 0;
            end else if (m_we) begin
                if (wait_cnt >= ack_delay) mem_ack = 1'b1;
                else wait_cnt++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstN && m_we && mem_ack) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                             m_addr, m_wdata);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", {24'b0, m_addr}, {24'b0, e.addr});
                    checkOutput("wr_data", m_wdata, e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic last,
                                 input logic [7:0] exp_addr, input logic [31:0] exp_word);
        bit ok = 1'b0;
        exp_q.push_back('{addr: exp_addr, data: exp_word});
        @(posedge clk);
        #1;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNote("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expectHalt(input logic [7:0] addr);
        exp_q.push_back('{addr: addr, data: HALT_WORD});
    endtask

    task automatic waitDone(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNote(name);
    endtask

    task automatic pulseRestart();
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acked;
        bit saw_ready;
        int stall;
        rstN = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        #3;
        checkOutput("rst_we", m_we, 1'b0);
        checkOutput("rst_done", m_done, 1'b0);
        checkOutput("rst_error", m_error, 1'b0);
        checkOutput("rst_full", m_full, 1'b0);
        checkOutput("rst_count", m_count, 9'd0);
        checkOutput("rst_ready", m_ready, 1'b1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // addi x1,x0,5 ; add x3,x1,x2 (last) ; halt
        applyStimulus(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 8'd0, 32'h0050_0093);
        applyStimulus(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 8'd1, 32'h0020_81B3);
        expectHalt(8'd2);
        waitDone("prog1_done");
        checkOutput("prog1_done", m_done, 1'b1);
        checkOutput("prog1_count", m_count, 9'd3);
        checkOutput("prog1_error", m_error, 1'b0);
        checkOutput("prog1_ready", m_ready, 1'b0);

        pulseRestart();
        @(negedge clk);
        checkOutput("restart_count", m_count, 9'd0);
        checkOutput("restart_done", m_done, 1'b0);

        // sw x2,8(x1) ; jal x1,8 (last) with a 5-cycle ack stall and an ignored restart
        applyStimulus(OP_S, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 8'd0, 32'h0020_A423);
        @(negedge clk);
        ack_delay = 5;
        applyStimulus(OP_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 8'd1, 32'h0080_00EF);
        stall = 0;
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            restart = 1'b0;
            if (mem_ack) begin
                acked = 1'b1;
                break;
            end
            stall++;
            checkOutput("stall_we", m_we, 1'b1);
            checkOutput("stall_addr", m_addr, 8'd1);
            checkOutput("stall_data", m_wdata, 32'h0080_00EF);
            checkOutput("stall_ready", m_ready, 1'b0);
            if (i == 2) restart = 1'b1;
        end
        if (!acked) failNote("stall_ack");
        checkOutput("stall_cycles", stall, 32'd5);
        ack_delay = 0;
        expectHalt(8'd2);
        waitDone("prog2_done");
        checkOutput("prog2_count", m_count, 9'd3);

        // unsupported opcode: zero word, sticky error, no separate halt write
        pulseRestart();
        applyStimulus(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 8'd0, 32'h0);
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_we && mem_ack) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) failNote("bad_op_ack");
        @(negedge clk);
        checkOutput("bad_op_done", m_done, 1'b1);
        checkOutput("bad_op_error", m_error, 1'b1);
        checkOutput("bad_op_we", m_we, 1'b0);
        checkOutput("bad_op_count", m_count, 9'd1);
        repeat (5) @(negedge clk);

        // reset asserted while a write is stalled
        pulseRestart();
        ack_delay = 10;
        applyStimulus(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 8'd0, 32'h0050_0093);
        @(negedge clk);
        checkOutput("pre_reset_we", m_we, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("reset_we", m_we, 1'b0);
        checkOutput("reset_count", m_count, 9'd0);
        checkOutput("reset_error", m_error, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b1;
        ack_delay = 0;
        applyStimulus(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 8'd0, 32'h0020_81B3);
        expectHalt(8'd1);
        waitDone("post_reset_done");
        checkOutput("post_reset_count", m_count, 9'd2);

        // 4-word memory, no last: three words, halt at 3, further bundles refused
        @(negedge clk);
        sel = 1'b1;
        applyStimulus(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 8'd0, 32'h0010_0093);
        applyStimulus(OP_I, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 8'd1, 32'h0020_0113);
        applyStimulus(OP_I, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 8'd2, 32'h0030_0193);
        expectHalt(8'd3);
        @(posedge clk);
        #1;
        in_opcode = OP_I; in_rd = 5'd4; in_imm = 32'd4; in_last = 1'b0;
        in_valid  = 1'b1;
        waitDone("full_done");
        saw_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_ready) saw_ready = 1'b1;
        end
        checkOutput("full_refused", saw_ready, 1'b0);
        checkOutput("full_flag", m_full, 1'b1);
        checkOutput("full_count", m_count, 9'd4);
        checkOutput("full_error", m_error, 1'b0);
        in_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
